// File: rtl/stack_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// stack_cmd_sequencer
//
// Upstream driver for a 5-entry, 4-bit level-sensitive stack. Host requests
// enter a small valid/ready queue. They are replayed onto the stack bus as one
// command cycle (ISSUE) followed by a mandatory nop cycle (GAP). Pop and get
// data come back as a one-cycle response pulse. The sequencer mirrors the
// stack occupancy so that it can flag overflow and underflow wrap-around.
//
// Optional build macro: STACK_SEQ_ERR_BLOCK_EN
//   defined   : erroneous ops are replaced by a nop on the stack bus. Pop/get
//               still respond, with RSP_ERR=1 and RSP_DATA=0.
//   undefined : erroneous ops are issued unchanged. Only flags and RSP_ERR
//               report them.
//
// Ports
//   notCLK       in   clock; its rising edge is the stack CLK falling edge
//   RESET        in   synchronous active-high reset
//   REQ_VALID    in   host request valid
//   REQ_READY    out  request queue not full (registered)
//   REQ_CMD      in   00 nop, 01 push, 10 pop, 11 get
//   REQ_INDEX    in   get index
//   REQ_DATA     in   push data
//   RSP_VALID    out  one-cycle response pulse
//   RSP_DATA     out  pop/get data
//   RSP_ERR      out  response belongs to an erroneous op
//   STK_COMMAND  out  stack COMMAND
//   STK_INDEX    out  stack INDEX
//   IO_DATA      io   shared stack data bus
//   COUNT        out  mirrored stack occupancy 0..STACK_DEPTH
//   OVERFLOW     out  sticky push-when-full flag
//   UNDERFLOW    out  sticky pop-when-empty flag
//   CLR_FLAGS    in   clears the sticky flags
// ---------------------------------------------------------------------------
module stack_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int STACK_DEPTH = 5
) (
    input  logic       notCLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_CMD,
    input  logic [2:0] REQ_INDEX,
    input  logic [3:0] REQ_DATA,
    output logic       RSP_VALID,
    output logic [3:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic [1:0] STK_COMMAND,
    output logic [2:0] STK_INDEX,
    inout  wire  [3:0] IO_DATA,
    output logic [2:0] COUNT,
    output logic       OVERFLOW,
    output logic       UNDERFLOW,
    input  logic       CLR_FLAGS
);

`ifdef STACK_SEQ_ERR_BLOCK_EN
    localparam bit ERR_BLOCK = 1'b1;
`else
    localparam bit ERR_BLOCK = 1'b0;
`endif

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  L_FULL = 3'(STACK_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_PUSH = 2'b01;
    localparam logic [1:0] C_POP  = 2'b10;

    // Request queue: {cmd, index, data}
    logic [8:0]    r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fifo_cnt;
    logic          r_req_ready;

    logic [1:0]    r_state;
    logic          r_op_rd;      // op in flight returns data
    logic          r_op_err;
    logic [1:0]    r_stk_cmd;
    logic [2:0]    r_stk_idx;
    logic          r_io_oe;
    logic [3:0]    r_io_out;
    logic          r_rsp_valid;
    logic [3:0]    r_rsp_data;
    logic          r_rsp_err;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic          r_unf;

    logic          w_accept;
    logic          w_deq;
    logic [AW:0]   w_fifo_cnt_next;
    logic [8:0]    w_head;
    logic [1:0]    w_head_cmd;
    logic [2:0]    w_head_idx;
    logic [3:0]    w_head_data;
    logic          w_err;
    logic          w_blocked;
    logic [2:0]    w_count_next;
    logic          w_ovf_set;
    logic          w_unf_set;

    // nop requests complete the handshake but are never written to the queue.
    assign w_accept = REQ_VALID && r_req_ready && (REQ_CMD != C_NOP);
    assign w_deq    = ((r_state == S_IDLE) || (r_state == S_GAP)) && (r_fifo_cnt != '0);
    assign w_fifo_cnt_next = r_fifo_cnt + (AW+1)'(w_accept) - (AW+1)'(w_deq);

    assign w_head      = r_fifo_mem[r_rd_ptr];
    assign w_head_cmd  = w_head[8:7];
    assign w_head_idx  = w_head[6:4];
    assign w_head_data = w_head[3:0];

    // Occupancy mirror and error classification of the head op at dequeue.
    always_comb begin
        w_err        = 1'b0;
        w_count_next = r_count;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        if (w_deq) begin
            case (w_head_cmd)
                C_PUSH: begin
                    if (r_count == L_FULL) begin
                        w_err     = 1'b1;
                        w_ovf_set = 1'b1;
                    end else begin
                        w_count_next = r_count + 3'd1;
                    end
                end
                C_POP: begin
                    if (r_count == 3'd0) begin
                        w_err     = 1'b1;
                        w_unf_set = 1'b1;
                    end else begin
                        w_count_next = r_count - 3'd1;
                    end
                end
                default: begin
                    w_err = (w_head_idx >= r_count);
                end
            endcase
        end
    end

    assign w_blocked = ERR_BLOCK && w_err;

    // Queue storage has no reset so it can map onto plain RAM.
    always_ff @(posedge notCLK) begin
        if (w_accept) begin
            r_fifo_mem[r_wr_ptr] <= {REQ_CMD, REQ_INDEX, REQ_DATA};
        end
    end

    always_ff @(posedge notCLK) begin
        if (RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
            r_op_rd     <= 1'b0;
            r_op_err    <= 1'b0;
            r_stk_cmd   <= C_NOP;
            r_stk_idx   <= 3'd0;
            r_io_oe     <= 1'b0;
            r_io_out    <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 4'd0;
            r_rsp_err   <= 1'b0;
            r_count     <= 3'd0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;

            // A new error on the same edge as CLR_FLAGS keeps the flag set.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (CLR_FLAGS) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (CLR_FLAGS) begin
                r_unf <= 1'b0;
            end

            // READY is registered from next occupancy, so no accept can
            // happen while the queue is full.
            r_fifo_cnt  <= w_fifo_cnt_next;
            r_req_ready <= (w_fifo_cnt_next != (AW+1)'(FIFO_DEPTH));
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_deq) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_count   <= w_count_next;
                r_state   <= S_ISSUE;
                r_op_rd   <= w_head_cmd[1];
                r_op_err  <= w_err;
                r_stk_cmd <= w_blocked ? C_NOP : w_head_cmd;
                r_stk_idx <= w_head_idx;
                r_io_oe   <= (w_head_cmd == C_PUSH) && !w_blocked;
                r_io_out  <= w_head_data;
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        // Stack drove IO_DATA during the CLK-high phase of
                        // ISSUE; sample it before releasing the command.
                        r_state   <= S_GAP;
                        r_stk_cmd <= C_NOP;
                        r_stk_idx <= 3'd0;
                        r_io_oe   <= 1'b0;
                        if (r_op_rd) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= r_op_err;
                            r_rsp_data  <= (ERR_BLOCK && r_op_err) ? 4'd0 : IO_DATA;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_io
            assign IO_DATA[gi] = r_io_oe ? r_io_out[gi] : 1'bz;
        end
    endgenerate

    assign REQ_READY   = r_req_ready;
    assign RSP_VALID   = r_rsp_valid;
    assign RSP_DATA    = r_rsp_data;
    assign RSP_ERR     = r_rsp_err;
    assign STK_COMMAND = r_stk_cmd;
    assign STK_INDEX   = r_stk_idx;
    assign COUNT       = r_count;
    assign OVERFLOW    = r_ovf;
    assign UNDERFLOW   = r_unf;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for stack_cmd_sequencer. A behavioural 5-entry wrapping stack
// sits on the bus. A reference model is applied at request time and fills
// three scoreboards: stack commands, responses, and COUNT changes. A monitor
// drains them as the DUT produces activity.
// ---------------------------------------------------------------------------
module tb_stack_cmd_sequencer;

`ifdef STACK_SEQ_ERR_BLOCK_EN
    localparam bit BLOCK = 1'b1;
`else
    localparam bit BLOCK = 1'b0;
`endif

    logic       notCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_CMD = 2'b00;
    logic [2:0] REQ_INDEX = 3'd0;
    logic [3:0] REQ_DATA = 4'd0;
    logic       RSP_VALID;
    logic [3:0] RSP_DATA;
    logic       RSP_ERR;
    logic [1:0] STK_COMMAND;
    logic [2:0] STK_INDEX;
    wire  [3:0] IO_DATA;
    logic [2:0] COUNT;
    logic       OVERFLOW;
    logic       UNDERFLOW;
    logic       CLR_FLAGS = 1'b0;

    always #5 notCLK = ~notCLK;

    stack_cmd_sequencer #(.FIFO_DEPTH(4), .STACK_DEPTH(5)) dut (
        .notCLK(notCLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CMD(REQ_CMD), .REQ_INDEX(REQ_INDEX), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .STK_COMMAND(STK_COMMAND), .STK_INDEX(STK_INDEX), .IO_DATA(IO_DATA),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
        .CLR_FLAGS(CLR_FLAGS)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural stack ----------------
    logic [3:0] stk_drv = 4'd0;
    logic       stk_oe = 1'b0;
    logic [3:0] dev_mem [5] = '{default: 4'd0};
    int         dev_sp = 0;

    assign IO_DATA = stk_oe ? stk_drv : 4'bzzzz;

    // Stack CLK rises on the falling edge of notCLK.
    initial forever begin
        @(negedge notCLK);
        if (RESET) begin
            stk_oe = 1'b0;
            dev_sp = 0;
        end else begin
            case (STK_COMMAND)
                2'b01: begin
                    dev_mem[dev_sp] = IO_DATA;
                    dev_sp = (dev_sp + 1) % 5;
                    stk_oe = 1'b0;
                end
                2'b10: begin
                    dev_sp = (dev_sp + 4) % 5;
                    stk_drv = dev_mem[dev_sp];
                    stk_oe = 1'b1;
                end
                2'b11: begin
                    stk_drv = dev_mem[(dev_sp - 1 - int'(STK_INDEX) + 10) % 5];
                    stk_oe = 1'b1;
                end
                default: stk_oe = 1'b0;
            endcase
        end
    end

    // ---------------- reference model + scoreboards ----------------
    typedef struct { logic [1:0] cmd; logic [2:0] idx; logic [3:0] data; } iss_t;
    typedef struct { logic [3:0] data; bit err; bit chk_data; } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   cnt_q[$];

    logic [3:0] ref_mem [5] = '{default: 4'd0};
    int  ref_sp = 0;
    int  ref_cnt = 0;
    bit  ref_ovf = 0;
    bit  ref_unf = 0;
    bit  saw_not_ready = 0;

    task automatic model(input logic [1:0] c, input logic [2:0] i, input logic [3:0] d);
        bit err;
        bit issue;
        logic [3:0] rd;
        iss_t e;
        rsp_t r;
        err = 0;
        rd = 4'd0;
        if (c == 2'b00) return;
        case (c)
            2'b01: begin
                err = (ref_cnt == 5);
                if (err) ref_ovf = 1;
                else begin ref_cnt++; cnt_q.push_back(ref_cnt); end
            end
            2'b10: begin
                err = (ref_cnt == 0);
                if (err) ref_unf = 1;
                else begin ref_cnt--; cnt_q.push_back(ref_cnt); end
            end
            default: err = (int'(i) >= ref_cnt);
        endcase
        issue = !(BLOCK && err);
        if (issue) begin
            if (c == 2'b01) begin
                ref_mem[ref_sp] = d;
                ref_sp = (ref_sp + 1) % 5;
            end else if (c == 2'b10) begin
                ref_sp = (ref_sp + 4) % 5;
                rd = ref_mem[ref_sp];
            end else begin
                rd = ref_mem[(ref_sp - 1 - int'(i) + 10) % 5];
            end
            e.cmd = c;
            e.idx = i;
            e.data = (c == 2'b01) ? d : 4'd0;
            iss_q.push_back(e);
        end
        if (c[1]) begin
            r.data = rd;
            r.err = err;
            r.chk_data = !err || BLOCK;
            rsp_q.push_back(r);
        end
    endtask

    // ---------------- monitor ----------------
    logic [2:0] last_cnt = 3'd0;
    logic [1:0] prev_cmd = 2'b00;

    initial forever begin
        @(posedge notCLK);
        #1;
        if (RESET) begin
            iss_q.delete();
            rsp_q.delete();
            cnt_q.delete();
            last_cnt = 3'd0;
            prev_cmd = 2'b00;
        end else begin
            if (RSP_VALID) begin
                $display("rsp  data=%0d err=%0b", RSP_DATA, RSP_ERR);
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_err", RSP_ERR, r.err);
                    if (r.chk_data) check("rsp_data", RSP_DATA, r.data);
                end
            end
            if (STK_COMMAND != 2'b00) begin
                $display("issue cmd=%0d idx=%0d io=%0h", STK_COMMAND, STK_INDEX, IO_DATA);
                if (prev_cmd != 2'b00) check("cmd_no_gap", STK_COMMAND, 0);
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("stk_cmd", STK_COMMAND, e.cmd);
                    check("stk_idx", STK_INDEX, e.idx);
                    if (e.cmd == 2'b01) check("push_io", IO_DATA, e.data);
                end
            end else if (!stk_oe) begin
                check("io_z", (IO_DATA === 4'bzzzz), 1);
            end
            if (COUNT != last_cnt) begin
                if (cnt_q.size() == 0) check("count_unexpected", COUNT, last_cnt);
                else check("count_seq", COUNT, cnt_q.pop_front());
                last_cnt = COUNT;
            end
            prev_cmd = STK_COMMAND;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] c, input logic [2:0] i, input logic [3:0] d);
        int tmo;
        @(negedge notCLK);
        REQ_VALID = 1'b1;
        REQ_CMD = c;
        REQ_INDEX = i;
        REQ_DATA = d;
        tmo = 0;
        while (!REQ_READY && tmo < 50) begin
            saw_not_ready = 1;
            @(negedge notCLK);
            tmo++;
        end
        if (tmo >= 50) begin
            check("ready_timeout", 0, 1);
            REQ_VALID = 1'b0;
        end else begin
            $display("req  cmd=%0d idx=%0d data=%0d", c, i, d);
            model(c, i, d);
        end
    endtask

    task automatic drain();
        int tmo;
        @(negedge notCLK);
        REQ_VALID = 1'b0;
        tmo = 0;
        while ((iss_q.size() != 0 || rsp_q.size() != 0) && tmo < 200) begin
            @(negedge notCLK);
            tmo++;
        end
        if (tmo >= 200) check("drain_timeout", 0, 1);
        repeat (3) @(negedge notCLK);
        check("cnt_q_left", cnt_q.size(), 0);
        check("count", COUNT, ref_cnt);
        check("overflow", OVERFLOW, ref_ovf);
        check("underflow", UNDERFLOW, ref_unf);
    endtask

    task automatic do_reset();
        @(negedge notCLK);
        RESET = 1'b1;
        REQ_VALID = 1'b0;
        CLR_FLAGS = 1'b0;
        repeat (2) @(negedge notCLK);
        RESET = 1'b0;
        ref_sp = 0;
        ref_cnt = 0;
        ref_ovf = 0;
        ref_unf = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int tmo;

        // Reset state, observed while RESET is still held.
        @(posedge notCLK);
        #1;
        check("rst_cmd", STK_COMMAND, 0);
        check("rst_idx", STK_INDEX, 0);
        check("rst_io_z", (IO_DATA === 4'bzzzz), 1);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_data", RSP_DATA, 0);
        check("rst_rsp_err", RSP_ERR, 0);
        check("rst_count", COUNT, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_unf", UNDERFLOW, 0);
        check("rst_ready", REQ_READY, 1);
        do_reset();

        // LIFO order, a nop in the stream, COUNT 1,2,3,2,1,0.
        send(2'b01, 3'd0, 4'd3);
        send(2'b00, 3'd0, 4'd15);
        send(2'b01, 3'd0, 4'd7);
        send(2'b01, 3'd0, 4'd9);
        send(2'b10, 3'd0, 4'd0);
        send(2'b10, 3'd0, 4'd0);
        send(2'b10, 3'd0, 4'd0);
        drain();

        // Get by index, including out-of-range.
        do_reset();
        for (int k = 1; k <= 5; k++) send(2'b01, 3'd0, 4'(k));
        send(2'b11, 3'd0, 4'd0);
        send(2'b11, 3'd4, 4'd0);
        send(2'b11, 3'd5, 4'd0);
        drain();

        // Overflow, then pop, then clear flags.
        do_reset();
        for (int k = 1; k <= 6; k++) send(2'b01, 3'd0, 4'(k));
        drain();
        send(2'b10, 3'd0, 4'd0);
        drain();
        @(negedge notCLK);
        CLR_FLAGS = 1'b1;
        @(negedge notCLK);
        CLR_FLAGS = 1'b0;
        ref_ovf = 0;
        check("ovf_cleared", OVERFLOW, ref_ovf);

        // Underflow.
        do_reset();
        send(2'b10, 3'd0, 4'd0);
        drain();
        @(negedge notCLK);
        CLR_FLAGS = 1'b1;
        @(negedge notCLK);
        CLR_FLAGS = 1'b0;
        ref_unf = 0;
        check("unf_cleared", UNDERFLOW, ref_unf);

        // Back-to-back pushes with VALID held: queue fills, READY drops.
        do_reset();
        saw_not_ready = 0;
        for (int k = 1; k <= 8; k++) send(2'b01, 3'd0, 4'(k + 2));
        check("ready_dropped", saw_not_ready, 1);
        drain();
        for (int k = 0; k < 5; k++) send(2'b10, 3'd0, 4'd0);
        drain();

        // Reset during the ISSUE cycle of a pop.
        do_reset();
        send(2'b01, 3'd0, 4'd4);
        send(2'b10, 3'd0, 4'd0);
        @(negedge notCLK);
        REQ_VALID = 1'b0;
        tmo = 0;
        do begin
            @(posedge notCLK);
            #1;
            tmo++;
        end while (STK_COMMAND != 2'b10 && tmo < 20);
        check("pop_issue_seen", STK_COMMAND, 2'b10);
        @(negedge notCLK);
        #1;
        RESET = 1'b1;
        ref_sp = 0;
        ref_cnt = 0;
        ref_ovf = 0;
        ref_unf = 0;
        @(posedge notCLK);
        #1;
        check("midrst_rsp_valid", RSP_VALID, 0);
        check("midrst_count", COUNT, 0);
        @(negedge notCLK);
        #1;
        RESET = 1'b0;
        @(posedge notCLK);
        #1;
        check("midrst_ready", REQ_READY, 1);
        check("midrst_io_z", (IO_DATA === 4'bzzzz), 1);
        check("midrst_no_rsp", RSP_VALID, 0);

        // Recovery after the abandoned op.
        send(2'b01, 3'd0, 4'd2);
        send(2'b10, 3'd0, 4'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
